mcc_ctrl_p: RTL and testbench

- Parametrised next-generation memristor crossbar compute (MCC) controller.
- Fetches N target conductances from main memory and programs them into an N-cell crossbar diagonal. Programming uses a program/sense/verify loop bounded by ITER_MAX.
- Then fetches an N-element input vector, drives it through the DAC, samples N column outputs via the ADC mux, and writes the N results back to memory.
- Sits between the CPU start/done interface, the main-memory port and the analog crossbar front end.

---
 rtl/mcc_pkg.sv | 24 ++
 rtl/mcc_ctrl_p_if.sv | 19 +
 rtl/mcc_mem_port.sv | 59 +++++
 rtl/mcc_ctrl_p.sv | 252 +++++++++++++++++++++++++
 tb/tb_mcc_ctrl_p.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcc_pkg.sv
// Shared types, default widths and helpers for the MCC crossbar controller.
package mcc_pkg;

  localparam int unsigned N_DEF        = 32;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned AW_DEF       = 32;
  localparam int unsigned ITER_MAX_DEF = 5;
  localparam int unsigned TOL_DEF      = 4;

  typedef enum logic [3:0] {
    IDLE, LOAD_W, PROG, SENSE, VERIFY, LOAD_X, DRIVE, EVAL, DONE
  } state_t;

  // Ceiling log2, minimum 1 so index ports never collapse to zero width.
  function automatic int unsigned clog2(input int unsigned v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return int'(r);
  endfunction

endpackage

// File: rtl/mcc_ctrl_p_if.sv
// Main-memory port of the MCC controller: single outstanding request/ready handshake.
interface mcc_ctrl_p_if
  import mcc_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic          mem_rdy;
  logic [DW-1:0] mem_data_in;

  modport master (output mem_en, mem_we, mem_addr, mem_data_out,
                  input  mem_rdy, mem_data_in);
  modport slave  (input  mem_en, mem_we, mem_addr, mem_data_out,
                  output mem_rdy, mem_data_in);
endinterface

// File: rtl/mcc_mem_port.sv
// Single-outstanding memory access engine; pins held stable until mem_rdy is sampled.
module mcc_mem_port
  import mcc_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_done,
  output logic [DW-1:0] o_rdata,
  mcc_ctrl_p_if.master  mem
);

  logic          r_en;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_done;
  logic [DW-1:0] r_rdata;

  // Ready is only honoured while a request is outstanding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_en) begin
        if (mem.mem_rdy) begin
          r_en    <= 1'b0;
          r_done  <= 1'b1;
          r_rdata <= mem.mem_data_in;
        end
      end else if (i_req) begin
        r_en    <= 1'b1;
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
    end
  end

  assign mem.mem_en       = r_en;
  assign mem.mem_we       = r_we;
  assign mem.mem_addr     = r_addr;
  assign mem.mem_data_out = r_wdata;
  assign o_done           = r_done;
  assign o_rdata          = r_rdata;

endmodule

// File: rtl/mcc_ctrl_p.sv
// MCC controller: load targets, program/verify the crossbar diagonal, then run one MVM pass.
module mcc_ctrl_p
  import mcc_pkg::*;
#(
  parameter  int unsigned N        = N_DEF,
  parameter  int unsigned DW       = DW_DEF,
  parameter  int unsigned AW       = AW_DEF,
  parameter  int unsigned ITER_MAX = ITER_MAX_DEF,
  parameter  int unsigned TOL      = TOL_DEF,
  localparam int unsigned IW       = clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ld_en,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] x_base,
  input  logic [AW-1:0] y_base,
  output logic          busy,
  output logic          y_final_rdy,
  output logic [AW-1:0] y_final_memaddr,
  output logic          prog_fail,
  output logic [IW:0]   fail_cnt,
  mcc_ctrl_p_if.master  mem,
  output logic [IW-1:0] dac_idx,
  output logic [DW-1:0] dac_data,
  output logic          dac_prog,
  output logic          dac_drive,
  output logic [IW-1:0] mux_sel,
  output logic          adc_req,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data
);

  localparam int unsigned   ITW       = clog2(ITER_MAX + 1);
  localparam logic [ITW-1:0] ITER_LAST = ITW'(ITER_MAX - 1);
  localparam logic [IW-1:0]  K_LAST    = IW'(N - 1);

  state_t          r_state;
  logic [IW-1:0]   r_k;
  logic [ITW-1:0]  r_iter;
  logic [DW-1:0]   r_tgt [N];
  logic [DW-1:0]   r_adc;
  logic [AW-1:0]   r_wb, r_xb, r_yb;
  logic            r_wait;
  logic            r_busy, r_y_rdy, r_prog_fail, r_dac_prog, r_dac_drive, r_adc_req;
  logic [AW-1:0]   r_y_addr;
  logic [IW:0]     r_fail_cnt;
  logic [IW-1:0]   r_dac_idx, r_mux_sel;
  logic [DW-1:0]   r_dac_data;

  logic            w_done;
  logic [DW-1:0]   w_rdata;
  logic            w_mem_req;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic [IW-1:0]   w_kn;
  logic [AW-1:0]   w_base_sel;
  logic [DW:0]     w_diff;
  logic            w_pass;

  // Next access issues in the completion cycle of the previous one, so k+1 is addressed.
  always_comb begin
    w_kn       = r_wait ? IW'(r_k + 1'b1) : r_k;
    w_base_sel = r_yb;
    w_mem_we   = 1'b0;
    w_mem_req  = 1'b0;
    case (r_state)
      LOAD_W: begin
        w_base_sel = r_wb;
        w_mem_req  = !r_wait || (w_done && (r_k != K_LAST));
      end
      LOAD_X: begin
        w_base_sel = r_xb;
        w_mem_req  = !r_wait || (w_done && (r_k != K_LAST));
      end
      EVAL: begin
        w_mem_we  = 1'b1;
        w_mem_req = r_adc_req && adc_valid;
      end
      default: ;
    endcase
    w_mem_addr = w_base_sel + AW'(w_kn);
    w_diff = ({1'b0, r_adc} >= {1'b0, r_tgt[r_k]}) ? ({1'b0, r_adc} - {1'b0, r_tgt[r_k]})
                                                  : ({1'b0, r_tgt[r_k]} - {1'b0, r_adc});
    w_pass = (w_diff <= (DW+1)'(TOL));
  end

  mcc_mem_port #(.AW(AW), .DW(DW)) u_mem_port (
    .clk     (clk),
    .rstn    (rstn),
    .i_req   (w_mem_req),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (adc_data),
    .o_done  (w_done),
    .o_rdata (w_rdata),
    .mem     (mem)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_iter      <= '0;
      for (int i = 0; i < int'(N); i++) r_tgt[i] <= '0;
      r_adc       <= '0;
      r_wb        <= '0;
      r_xb        <= '0;
      r_yb        <= '0;
      r_wait      <= 1'b0;
      r_busy      <= 1'b0;
      r_y_rdy     <= 1'b0;
      r_y_addr    <= '0;
      r_prog_fail <= 1'b0;
      r_fail_cnt  <= '0;
      r_dac_prog  <= 1'b0;
      r_dac_drive <= 1'b0;
      r_dac_idx   <= '0;
      r_dac_data  <= '0;
      r_mux_sel   <= '0;
      r_adc_req   <= 1'b0;
    end else begin
      r_dac_prog  <= 1'b0;
      r_dac_drive <= 1'b0;
      r_y_rdy     <= 1'b0;
      if (w_mem_req)   r_wait <= 1'b1;
      else if (w_done) r_wait <= 1'b0;

      case (r_state)
        IDLE: if (ld_en) begin
          r_wb        <= w_base;
          r_xb        <= x_base;
          r_yb        <= y_base;
          r_prog_fail <= 1'b0;
          r_fail_cnt  <= '0;
          r_k         <= '0;
          r_iter      <= '0;
          r_busy      <= 1'b1;
          r_state     <= LOAD_W;
        end
        LOAD_W: if (w_done) begin
          r_tgt[r_k] <= w_rdata;
          if (r_k == K_LAST) begin
            r_k        <= '0;
            r_iter     <= '0;
            r_state    <= PROG;
            r_dac_prog <= 1'b1;
            r_dac_idx  <= '0;
            r_dac_data <= r_tgt[0];
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        PROG: begin
          r_state   <= SENSE;
          r_adc_req <= 1'b1;
          r_mux_sel <= r_k;
        end
        SENSE: if (adc_valid) begin
          r_adc_req <= 1'b0;
          r_adc     <= adc_data;
          r_state   <= VERIFY;
        end
        VERIFY: begin
          if (w_pass || (r_iter == ITER_LAST)) begin
            if (!w_pass) begin
              r_prog_fail <= 1'b1;
              r_fail_cnt  <= r_fail_cnt + 1'b1;
            end
            r_iter <= '0;
            if (r_k == K_LAST) begin
              r_k     <= '0;
              r_state <= LOAD_X;
            end else begin
              r_k        <= r_k + 1'b1;
              r_state    <= PROG;
              r_dac_prog <= 1'b1;
              r_dac_idx  <= IW'(r_k + 1'b1);
              r_dac_data <= r_tgt[IW'(r_k + 1'b1)];
            end
          end else begin
            r_iter     <= r_iter + 1'b1;
            r_state    <= PROG;
            r_dac_prog <= 1'b1;
            r_dac_idx  <= r_k;
            r_dac_data <= r_tgt[r_k];
          end
        end
        // Input vector overwrites the targets, which are no longer needed.
        LOAD_X: if (w_done) begin
          r_tgt[r_k] <= w_rdata;
          if (r_k == K_LAST) begin
            r_k         <= '0;
            r_state     <= DRIVE;
            r_dac_drive <= 1'b1;
            r_dac_idx   <= '0;
            r_dac_data  <= r_tgt[0];
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DRIVE: begin
          if (r_k == K_LAST) begin
            r_k       <= '0;
            r_state   <= EVAL;
            r_adc_req <= 1'b1;
            r_mux_sel <= '0;
          end else begin
            r_k         <= r_k + 1'b1;
            r_dac_drive <= 1'b1;
            r_dac_idx   <= IW'(r_k + 1'b1);
            r_dac_data  <= r_tgt[IW'(r_k + 1'b1)];
          end
        end
        // The captured ADC word goes straight into the write request.
        EVAL: begin
          if (r_adc_req && adc_valid) r_adc_req <= 1'b0;
          if (w_done) begin
            if (r_k == K_LAST) begin
              r_state  <= DONE;
              r_busy   <= 1'b0;
              r_y_rdy  <= 1'b1;
              r_y_addr <= r_yb;
            end else begin
              r_k       <= r_k + 1'b1;
              r_adc_req <= 1'b1;
              r_mux_sel <= IW'(r_k + 1'b1);
            end
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_y_addr <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign y_final_rdy     = r_y_rdy;
  assign y_final_memaddr = r_y_addr;
  assign prog_fail       = r_prog_fail;
  assign fail_cnt        = r_fail_cnt;
  assign dac_idx         = r_dac_idx;
  assign dac_data        = r_dac_data;
  assign dac_prog        = r_dac_prog;
  assign dac_drive       = r_dac_drive;
  assign mux_sel         = r_mux_sel;
  assign adc_req         = r_adc_req;

endmodule

// File: tb/tb_mcc_ctrl_p.sv
// Scoreboard bench for mcc_ctrl_p: memory/ADC/DAC models with queued expected writes and completions.
module tb_mcc_ctrl_p;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] w_base = '0, x_base = '0, y_base = '0;
  logic          busy, y_final_rdy, prog_fail, dac_prog, dac_drive, adc_req;
  logic [AW-1:0] y_final_memaddr;
  logic [2:0]    fail_cnt;
  logic [1:0]    dac_idx, mux_sel;
  logic [DW-1:0] dac_data;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] adc_data = '0;

  mcc_ctrl_p_if #(.AW(AW), .DW(DW)) mif ();

  mcc_ctrl_p #(.N(N), .DW(DW), .AW(AW), .ITER_MAX(5), .TOL(4)) dut (
    .clk(clk), .rstn(rstn), .ld_en(ld_en),
    .w_base(w_base), .x_base(x_base), .y_base(y_base),
    .busy(busy), .y_final_rdy(y_final_rdy), .y_final_memaddr(y_final_memaddr),
    .prog_fail(prog_fail), .fail_cnt(fail_cnt), .mem(mif),
    .dac_idx(dac_idx), .dac_data(dac_data), .dac_prog(dac_prog), .dac_drive(dac_drive),
    .mux_sel(mux_sel), .adc_req(adc_req), .adc_valid(adc_valid), .adc_data(adc_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] mem_arr [logic [31:0]];
  logic [63:0] wq [$];
  logic [36:0] cq [$];
  logic [31:0] rd_log [$];
  int          wmax = 0;
  bit          spur = 1'b0;
  int          mode = 0;
  logic [31:0] g [N];
  logic [31:0] xv [N];
  int          pcnt [N];
  int          scnt [N];
  bit          drove = 1'b0;
  int          done_cnt = 0;

  // Memory slave: random waits, stability check, write scoreboard, optional stray ready.
  initial begin : mem_resp
    bit          acc;
    int          left;
    logic [31:0] a, d;
    logic        w;
    logic [63:0] e;
    acc = 1'b0; left = 0; a = '0; d = '0; w = 1'b0;
    mif.mem_rdy = 1'b0;
    mif.mem_data_in = '0;
    forever begin
      @(negedge clk);
      mif.mem_rdy = 1'b0;
      if (!rstn) begin
        acc = 1'b0;
      end else if (mif.mem_en) begin
        if (!acc) begin
          acc = 1'b1;
          left = (wmax > 0) ? int'($urandom_range(0, wmax)) : 0;
          a = mif.mem_addr; w = mif.mem_we; d = mif.mem_data_out;
        end else begin
          chk("mem_stable", {31'd0, mif.mem_we, mif.mem_addr, mif.mem_data_out}, {31'd0, w, a, d});
        end
        if (left == 0) begin
          mif.mem_rdy = 1'b1;
          acc = 1'b0;
          if (w) begin
            if (wq.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_write: got addr %0h data %0h expected none", a, d);
            end else begin
              e = wq.pop_front();
              chk("y_write", {32'd0, a, d}, {32'd0, e});
            end
          end else begin
            mif.mem_data_in = mem_arr.exists(a) ? mem_arr[a] : 32'h0;
            rd_log.push_back(a);
          end
        end else begin
          left--;
        end
      end else if (spur && ($urandom_range(0, 2) == 0)) begin
        mif.mem_rdy = 1'b1;
        mif.mem_data_in = 32'hBAD0_BAD0;
      end
    end
  end

  // Crossbar model: tracks programmed conductances and driven inputs, answers ADC requests.
  initial begin : adc_resp
    bit          seen;
    logic [31:0] v;
    int          s;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      adc_valid = 1'b0;
      if (dac_prog) begin g[dac_idx] = dac_data; pcnt[dac_idx]++; end
      if (dac_drive) begin xv[dac_idx] = dac_data; drove = 1'b1; end
      chk("exclusive", {94'd0, dac_prog & dac_drive, mif.mem_en & adc_req}, 96'd0);
      if (adc_req) begin
        if (seen) begin
          s = int'(mux_sel);
          if (drove) v = xv[s] * g[s];
          else begin
            v = g[s];
            if (mode == 2 && s == 2 && scnt[2] < 2) v = v + 32'd9;
            if (mode == 3 && s == 1) v = v + 32'd5;
            scnt[s]++;
          end
          adc_valid = 1'b1;
          adc_data = v;
          seen = 1'b0;
        end else seen = 1'b1;
      end else begin
        seen = 1'b0;
        if (spur && ($urandom_range(0, 2) == 0)) begin
          adc_valid = 1'b1;
          adc_data = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Completion monitor.
  initial begin : cmp_mon
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (y_final_rdy) begin
        done_cnt++;
        if (cq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got addr %0h expected no completion", y_final_memaddr);
        end else begin
          e = cq.pop_front();
          chk("completion", {59'd0, y_final_memaddr, busy, prog_fail, fail_cnt}, {59'd0, e});
        end
      end
    end
  end

  task automatic check_zero(input string name);
    chk(name, {17'd0, busy, y_final_rdy, y_final_memaddr, prog_fail, fail_cnt, mif.mem_en,
               mif.mem_we, mif.mem_addr, dac_prog, dac_drive, adc_req, dac_idx, mux_sel}, 96'd0);
    chk({name, "_data"}, {32'd0, mif.mem_data_out, dac_data}, 96'd0);
  endtask

  task automatic start_run(input logic [31:0] wb, xb, yb, input int md, wm, input bit sp,
                           input bit exp_pf, input int exp_fc);
    logic [31:0] wv [N];
    logic [31:0] xi [N];
    logic [31:0] yv [N];
    wv = '{32'd10, 32'd20, 32'd30, 32'd40};
    xi = '{32'd1, 32'd2, 32'd3, 32'd4};
    yv = '{32'd10, 32'd40, 32'd90, 32'd160};
    for (int k = 0; k < N; k++) begin
      mem_arr[wb + 32'(k)] = wv[k];
      mem_arr[xb + 32'(k)] = xi[k];
      wq.push_back({yb + 32'(k), yv[k]});
      pcnt[k] = 0; scnt[k] = 0;
    end
    cq.push_back({yb, 1'b0, exp_pf, 3'(exp_fc)});
    mode = md; wmax = wm; spur = sp; drove = 1'b0;
    rd_log.delete();
    @(negedge clk);
    w_base = wb; x_base = xb; y_base = yb; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    chk("busy_after_start", {95'd0, busy}, 96'd1);
  endtask

  task automatic finish_run(input int done0, exp_p1, exp_p2, exp_tot, input bit exp_pf);
    for (int c = 0; c < 3000 && done_cnt == done0; c++) @(negedge clk);
    if (done_cnt == done0) begin
      checks++; failures++;
      $display("FAIL run_timeout: got no y_final_rdy expected one within 3000 cycles");
    end
    repeat (6) @(negedge clk);
    chk("done_pulses", 96'(done_cnt - done0), 96'd1);
    chk("prog_idx1", 96'(pcnt[1]), 96'(exp_p1));
    chk("prog_idx2", 96'(pcnt[2]), 96'(exp_p2));
    chk("prog_total", 96'(pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3]), 96'(exp_tot));
    chk("prog_fail_hold", {95'd0, prog_fail}, {95'd0, exp_pf});
    chk("writes_drained", 96'(wq.size()), 96'd0);
    chk("busy_idle", {95'd0, busy}, 96'd0);
  endtask

  initial begin : main
    int  d0;
    bit  quiet;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rstn = 1'b1;

    d0 = done_cnt;
    start_run(32'h100, 32'h200, 32'h300, 0, 0, 1'b0, 1'b0, 0);
    finish_run(d0, 1, 1, 4, 1'b0);

    d0 = done_cnt;
    start_run(32'h400, 32'h500, 32'h600, 2, 0, 1'b0, 1'b0, 0);
    finish_run(d0, 1, 3, 6, 1'b0);

    d0 = done_cnt;
    start_run(32'h700, 32'h800, 32'h900, 3, 0, 1'b0, 1'b1, 1);
    finish_run(d0, 5, 1, 8, 1'b1);

    d0 = done_cnt;
    start_run(32'hA00, 32'hB00, 32'hC00, 0, 3, 1'b1, 1'b0, 0);
    finish_run(d0, 1, 1, 4, 1'b0);

    // Start request during EVAL must not restart the run.
    d0 = done_cnt;
    start_run(32'h1100, 32'h1200, 32'h1300, 0, 1, 1'b0, 1'b0, 0);
    for (int c = 0; c < 2000 && !(drove && adc_req); c++) @(negedge clk);
    chk("reached_eval", {94'd0, drove, adc_req}, 96'd3);
    w_base = 32'h5000; x_base = 32'h6000; y_base = 32'h7000; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    finish_run(d0, 1, 1, 4, 1'b0);

    // Reset in the middle of programming.
    d0 = done_cnt;
    start_run(32'h2100, 32'h2200, 32'h2300, 0, 0, 1'b0, 1'b0, 0);
    for (int c = 0; c < 2000 && !dac_prog; c++) @(negedge clk);
    chk("reached_prog", {95'd0, dac_prog}, 96'd1);
    rstn = 1'b0;
    #1;
    check_zero("reset_midrun");
    wq.delete(); cq.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (mif.mem_en || dac_prog || dac_drive || adc_req || busy) quiet = 1'b0;
    end
    chk("quiet_after_reset", {95'd0, quiet}, 96'd1);
    chk("no_done_after_reset", 96'(done_cnt - d0), 96'd0);

    d0 = done_cnt;
    start_run(32'h3100, 32'h3200, 32'h3300, 0, 0, 1'b0, 1'b0, 0);
    finish_run(d0, 1, 1, 4, 1'b0);

    // Target fetch wraps past the top of the address space.
    d0 = done_cnt;
    start_run(32'hFFFF_FFFE, 32'h10, 32'h20, 0, 0, 1'b0, 1'b0, 0);
    finish_run(d0, 1, 1, 4, 1'b0);
    chk("rd_count", 96'(rd_log.size()), 96'd8);
    if (rd_log.size() >= 4) begin
      chk("wrap_rd0", 96'(rd_log[0]), 96'hFFFF_FFFE);
      chk("wrap_rd1", 96'(rd_log[1]), 96'hFFFF_FFFF);
      chk("wrap_rd2", 96'(rd_log[2]), 96'h0);
      chk("wrap_rd3", 96'(rd_log[3]), 96'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
